// File: rtl/calc_stack_engine.sv
// -----------------------------------------------------------------------------
// calc_stack_engine
//   Multi-bank bit-stack calculation engine. NBANK independent bit stacks of
//   DEPTH entries each. Every accepted instruction shifts/writes the active
//   bank, then the active bank pointer rotates round-robin. A flush request
//   runs a sequential clear of all banks (one bank per cycle).
//
//   Optional feature: define CALC_STACK_ERR_EN to add per-bank occupancy
//   counters with sticky overflow/underflow flags (ports stack_level,
//   err_ovf, err_unf).
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready instruction handshake; accept = in_valid & in_ready
//   lut, op, val      operand inputs (lookup table, op code, input bit)
//   do_pop, en_pop, en_push, en_push_force   shift control
//   en_stack_wr, mux_sta                     entry-0 write enable / source
//   flush             start bank-clear sequence
//   bank_sel          active bank pointer
//   out_stack         low OUT_W bits of the active bank
//   out_res/out_valid registered result and one-cycle valid pulse
//   db_stack          all banks, bank k at [k*DEPTH +: DEPTH]
// -----------------------------------------------------------------------------
module calc_stack_engine #(
    parameter int DEPTH = 6,
    parameter int NBANK = 2,
    parameter int OUT_W = 5,
    localparam int BW = (NBANK > 1) ? $clog2(NBANK) : 1,
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             lut,
    input  logic [1:0]             op,
    input  logic                   val,
    input  logic                   do_pop,
    input  logic                   en_push_force,
    input  logic                   en_pop,
    input  logic                   en_push,
    input  logic                   en_stack_wr,
    input  logic [1:0]             mux_sta,
    input  logic                   flush,
    output logic [BW-1:0]          bank_sel,
    output logic [OUT_W-1:0]       out_stack,
    output logic                   out_res,
    output logic                   out_valid,
`ifdef CALC_STACK_ERR_EN
    output logic [LW-1:0]          stack_level,
    output logic                   err_ovf,
    output logic                   err_unf,
`endif
    output logic [NBANK*DEPTH-1:0] db_stack
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t                   state_r;
    state_t                   state_nxt_s;
    logic [BW-1:0]            bank_r;
    logic [BW-1:0]            flush_idx_r;
    logic [NBANK*DEPTH-1:0]   stack_r;
    logic                     out_res_r;
    logic                     out_valid_r;

    logic                     in_ready_s;
    logic                     accept_s;
    logic                     pop_ev_s;
    logic                     push_ev_s;
    logic                     push_only_s;
    logic                     pop_only_s;
    logic                     lu_op_s;
    logic                     lu_acc_s;
    logic                     wdat_s;
    logic                     bank_last_s;
    logic                     flush_last_s;
    logic [BW-1:0]            bank_nxt_s;
    int                       bank_base_s;
    int                       flush_base_s;
    logic [DEPTH-1:0]         cur_s;
    logic [DEPTH-1:0]         shifted_s;
    logic [DEPTH-1:0]         upd_s;

    // Handshake, event decode and active-bank view.
    always_comb begin
        in_ready_s   = (state_r == ST_RUN) & ~flush;
        accept_s     = in_valid & in_ready_s;
        pop_ev_s     = en_pop & do_pop;
        push_ev_s    = (en_push & ~do_pop) | en_push_force;
        push_only_s  = push_ev_s & ~pop_ev_s;
        pop_only_s   = pop_ev_s & ~push_ev_s;
        bank_base_s  = int'(bank_r) * DEPTH;
        flush_base_s = int'(flush_idx_r) * DEPTH;
        cur_s        = stack_r[bank_base_s +: DEPTH];
        bank_last_s  = (bank_r == BW'(NBANK - 1));
        flush_last_s = (flush_idx_r == BW'(NBANK - 1));
        bank_nxt_s   = bank_last_s ? {BW{1'b0}} : (bank_r + BW'(1));
        lu_op_s      = lut[op];
        lu_acc_s     = |({val, cur_s[0]} ^ op);
    end

    // Write-data source select; both 0x codes pick the input bit.
    always_comb begin
        wdat_s = val;
        case (mux_sta)
            2'b00:   wdat_s = val;
            2'b01:   wdat_s = val;
            2'b10:   wdat_s = lu_op_s;
            2'b11:   wdat_s = lu_acc_s;
            default: wdat_s = val;
        endcase
    end

    // Shift of the active bank followed by the optional entry-0 overwrite.
    always_comb begin
        shifted_s = cur_s;
        case ({push_ev_s, pop_ev_s})
            2'b10:   shifted_s = {cur_s[DEPTH-2:0], 1'b0};
            2'b01:   shifted_s = {1'b0, cur_s[DEPTH-1:1]};
            default: shifted_s = cur_s;
        endcase
        upd_s = shifted_s;
        if (en_stack_wr) begin
            upd_s[0] = wdat_s;
        end else begin
            upd_s[0] = shifted_s[0];
        end
    end

    // Flush state machine next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (flush) begin
                    state_nxt_s = ST_FLUSH;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (flush_last_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_FLUSH;
                end
            end
            default: state_nxt_s = ST_RUN;
        endcase
    end

    // Flush state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Stack banks, bank pointer, flush index and registered result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stack_r     <= '0;
            bank_r      <= '0;
            flush_idx_r <= '0;
            out_res_r   <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    flush_idx_r <= '0;
                    out_valid_r <= accept_s;
                    if (accept_s) begin
                        stack_r[bank_base_s +: DEPTH] <= upd_s;
                        bank_r    <= bank_nxt_s;
                        out_res_r <= wdat_s;
                    end
                end
                ST_FLUSH: begin
                    out_valid_r <= 1'b0;
                    stack_r[flush_base_s +: DEPTH] <= '0;
                    if (flush_last_s) begin
                        bank_r      <= '0;
                        flush_idx_r <= '0;
                    end else begin
                        flush_idx_r <= flush_idx_r + BW'(1);
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef CALC_STACK_ERR_EN
    logic [NBANK*LW-1:0] level_r;
    logic                err_ovf_r;
    logic                err_unf_r;
    logic [LW-1:0]       cur_level_s;
    int                  level_base_s;

    // Occupancy of the active bank.
    always_comb begin
        level_base_s = int'(bank_r) * LW;
        cur_level_s  = level_r[level_base_s +: LW];
    end

    // Per-bank occupancy counters; saturate and raise sticky errors at the limits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_r   <= '0;
            err_ovf_r <= 1'b0;
            err_unf_r <= 1'b0;
        end else if ((state_r == ST_FLUSH) && flush_last_s) begin
            level_r   <= '0;
            err_ovf_r <= 1'b0;
            err_unf_r <= 1'b0;
        end else if (accept_s && push_only_s) begin
            if (cur_level_s == LW'(DEPTH)) begin
                err_ovf_r <= 1'b1;
            end else begin
                level_r[level_base_s +: LW] <= cur_level_s + LW'(1);
            end
        end else if (accept_s && pop_only_s) begin
            if (cur_level_s == LW'(0)) begin
                err_unf_r <= 1'b1;
            end else begin
                level_r[level_base_s +: LW] <= cur_level_s - LW'(1);
            end
        end else begin
            level_r <= level_r;
        end
    end

    assign stack_level = cur_level_s;
    assign err_ovf     = err_ovf_r;
    assign err_unf     = err_unf_r;
`endif

    assign in_ready  = in_ready_s;
    assign bank_sel  = bank_r;
    assign out_stack = cur_s[OUT_W-1:0];
    assign out_res   = out_res_r;
    assign out_valid = out_valid_r;
    assign db_stack  = stack_r;

endmodule
